// File: rtl/clk_meter.sv
// clk_meter: measures period and high time of an asynchronous square wave
// in clkin cycles.
//   clkin/rst_n  : system clock, async active-low reset
//   en           : measurement enable (0 forces idle)
//   sig_in       : asynchronous signal under measurement
//   period       : cycles between the last two rising edges
//   high_time    : cycles from a rising edge to the following falling edge
//   valid        : one-cycle pulse when period/high_time update
//   locked       : last two completed periods were equal
//   timeout      : sticky stall flag, cleared by the next valid
module clk_meter #(
  parameter int          SYNC_STAGES = 2,
  parameter int          CNT_W       = 32,
  parameter int unsigned TIMEOUT     = 50000000
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             timeout
);

  typedef enum logic [1:0] {
    IDLE,
    FIRST,
    RUN
  } state_e;

  localparam logic [CNT_W-1:0] TO_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;
  logic                   s;
  logic                   rise;
  logic                   fall;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] prev_q, prev_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             locked_q, locked_d;
  logic             timeout_q, timeout_d;

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      s_d_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_d_q;
  assign fall = ~s & s_d_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    prev_d    = prev_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    locked_d  = locked_q;
    timeout_d = timeout_q;

    if (!en) begin
      state_d  = IDLE;
      cnt_d    = '0;
      locked_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (rise) begin
            cnt_d   = ONE_C;
            state_d = FIRST;
          end
        end
        FIRST, RUN: begin
          // A rise on the timeout cycle still completes the period.
          if (rise) begin
            cnt_d   = ONE_C;
            prev_d  = cnt_q;
            state_d = RUN;
            if (state_q == RUN) begin
              period_d  = cnt_q;
              high_d    = hi_q;
              valid_d   = 1'b1;
              locked_d  = (cnt_q == prev_q);
              timeout_d = 1'b0;
            end
          end else if (cnt_q == TO_C) begin
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            state_d   = IDLE;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_q + ONE_C;
            if (fall) begin
              hi_d = cnt_q;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      prev_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      prev_q    <= prev_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      locked_q  <= locked_d;
      timeout_q <= timeout_d;
    end
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign valid     = valid_q;
  assign locked    = locked_q;
  assign timeout   = timeout_q;

endmodule
